// File: rtl/requant_pkg.sv
// requant_pkg: shared types, Q31 constants and TFLM-style fixed-point helpers for requant_drain
package requant_pkg;
  typedef logic signed [31:0] acc_t;
  typedef logic signed [7:0] q8_t;
  typedef struct packed {
    acc_t mult;
    logic signed [5:0] shift;
    q8_t zp;
    q8_t act_min;
    q8_t act_max;
  } quant_cfg_t;
  localparam quant_cfg_t CFG_RESET = '{mult: '0, shift: '0, zp: '0, act_min: 8'sh80, act_max: 8'sh7F};
  localparam logic signed [63:0] Q31_NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] Q31_NUDGE_NEG = -64'sd1073741823;
  localparam acc_t ACC_MIN = 32'sh80000000;
  function automatic acc_t srdhm(acc_t a, acc_t b);
    logic signed [63:0] p, t;
    p = 64'(a) * 64'(b);
    t = p + (p[63] ? Q31_NUDGE_NEG : Q31_NUDGE_POS);
    // floor shift, then bump negatives with a remainder to get truncation toward zero
    return (a == ACC_MIN && b == ACC_MIN) ? 32'sh7FFFFFFF
         : acc_t'(t >>> 31) + acc_t'({31'd0, t[63] && |t[30:0]});
  endfunction
  function automatic acc_t rdpot(acc_t x, logic [4:0] s);
    logic [31:0] mask, rem, thr;
    mask = (32'd1 << s) - 32'd1;
    rem = x & mask;
    thr = (mask >> 1) + {31'd0, x[31]};
    return (x >>> s) + acc_t'({31'd0, rem > thr});
  endfunction
endpackage

// File: rtl/requant_lane.sv
// requant_lane: one lane of the two-stage requantizer (S1 shift+multiply, S2 round/zero point/clamp)
module requant_lane
  import requant_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  acc_t       acc,
  input  quant_cfg_t cfg,
  output q8_t        q
);
  acc_t a_sh, h, r;
  logic signed [32:0] v;
  q8_t q_n;
  always_comb begin
    a_sh = cfg.shift > 0 ? acc <<< cfg.shift[4:0] : acc;
    r = cfg.shift < 0 ? rdpot(h, 5'(-cfg.shift)) : h;
    v = 33'(r) + 33'(cfg.zp);
    q_n = v < 33'(cfg.act_min) ? cfg.act_min : v > 33'(cfg.act_max) ? cfg.act_max : q8_t'(v[7:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      q <= '0;
    end else if (en) begin
      h <= srdhm(a_sh, cfg.mult);
      q <= q_n;
    end
  end
endmodule

// File: rtl/requant_drain.sv
// requant_drain: row FIFO + per-lane int32->int8 requantizer with valid/ready output.
// Optional per-lane bias via macro REQUANT_DRAIN_BIAS_EN.
module requant_drain
  import requant_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in [0:SIZE-1],
  input  logic                         calc_done_i,
  input  logic                         tile_calc_over_i,
  input  logic                         cfg_load_i,
  input  logic signed [31:0]           quant_mult_i,
  input  logic signed [5:0]            quant_shift_i,
  input  logic signed [7:0]            out_zp_i,
  input  logic signed [7:0]            act_min_i,
  input  logic signed [7:0]            act_max_i,
`ifdef REQUANT_DRAIN_BIAS_EN
  input  acc_t                         bias_i [0:SIZE-1],
`endif
  output logic [SIZE*8-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         idle_o,
  output logic                         ovf_o,
  output logic                         row_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(SIZE + 1);
  logic [SIZE*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [SIZE*DATA_WIDTH-1:0] din_row, dout_row;
  logic [AW:0] wp, rp;
  logic full, empty, adv, pop, push, s1_valid;
  logic [15:0] wr_row_cnt;
  logic [RW-1:0] rd_row_cnt;
  quant_cfg_t cfg;
`ifdef REQUANT_DRAIN_BIAS_EN
  acc_t bias_r [0:SIZE-1];
`endif
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign adv = !out_valid || out_ready;
  assign pop = adv && !empty;
  // a full FIFO still accepts a row when the same edge pops one
  assign push = calc_done_i && (!full || pop);
  assign dout_row = mem[rp[AW-1:0]];
  assign idle_o = empty && !s1_valid && !out_valid;
  assign out_last = out_valid && rd_row_cnt == RW'(SIZE - 1);
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    acc_t a;
    assign din_row[i*DATA_WIDTH +: DATA_WIDTH] = data_in[i];
`ifdef REQUANT_DRAIN_BIAS_EN
    assign a = acc_t'(dout_row[i*DATA_WIDTH +: DATA_WIDTH]) + bias_r[i];
`else
    assign a = acc_t'(dout_row[i*DATA_WIDTH +: DATA_WIDTH]);
`endif
    requant_lane u_lane (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .acc (a),
      .cfg (cfg),
      .q   (out_data[i*8 +: 8])
    );
  end
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= din_row;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      ovf_o <= 1'b0;
      row_err_o <= 1'b0;
      wr_row_cnt <= '0;
      rd_row_cnt <= '0;
      cfg <= CFG_RESET;
`ifdef REQUANT_DRAIN_BIAS_EN
      bias_r <= '{default: '0};
`endif
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (adv) begin
        s1_valid <= !empty;
        out_valid <= s1_valid;
      end
      if (calc_done_i && full && !pop) ovf_o <= 1'b1;
      if (tile_calc_over_i) begin
        if (wr_row_cnt + 16'(calc_done_i) != 16'(SIZE)) row_err_o <= 1'b1;
        wr_row_cnt <= '0;
      end else if (calc_done_i) wr_row_cnt <= wr_row_cnt + 1'b1;
      if (out_valid && out_ready) rd_row_cnt <= rd_row_cnt == RW'(SIZE - 1) ? '0 : rd_row_cnt + 1'b1;
      if (cfg_load_i && idle_o) begin
        cfg <= '{mult: quant_mult_i, shift: quant_shift_i, zp: out_zp_i, act_min: act_min_i, act_max: act_max_i};
`ifdef REQUANT_DRAIN_BIAS_EN
        bias_r <= bias_i;
`endif
      end
    end
  end
endmodule

// File: tb/tb_requant_drain.sv
// tb_requant_drain: directed checks of requant_drain (depth-16 and depth-4 instances side by side)
module tb_requant_drain;
  import requant_pkg::*;
  localparam int SIZE = 16;
  logic clk = 0, rst = 1, calc_done = 0, tile_over = 0, cfg_load = 0, out_ready = 1;
  acc_t data_in [0:SIZE-1];
  acc_t mult = 0;
  logic signed [5:0] shift = 0;
  q8_t zp = 0, amin = 8'sh80, amax = 8'sh7F;
  logic [SIZE*8-1:0] od, od4;
  logic ov, ol, idle, ovf, rerr, ov4, ol4, idle4, ovf4, rerr4;
  int tests = 0, fails = 0, n_out, n_last;
  always #5 clk = ~clk;
  requant_drain #(.SIZE(SIZE), .DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .calc_done_i(calc_done), .tile_calc_over_i(tile_over),
    .cfg_load_i(cfg_load), .quant_mult_i(mult), .quant_shift_i(shift), .out_zp_i(zp),
    .act_min_i(amin), .act_max_i(amax), .out_data(od), .out_valid(ov), .out_ready(out_ready),
    .out_last(ol), .idle_o(idle), .ovf_o(ovf), .row_err_o(rerr)
  );
  requant_drain #(.SIZE(SIZE), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .calc_done_i(calc_done), .tile_calc_over_i(tile_over),
    .cfg_load_i(cfg_load), .quant_mult_i(mult), .quant_shift_i(shift), .out_zp_i(zp),
    .act_min_i(amin), .act_max_i(amax), .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
    .out_last(ol4), .idle_o(idle4), .ovf_o(ovf4), .row_err_o(rerr4)
  );
  always @(posedge clk) begin
    if (rst) begin
      n_out <= 0;
      n_last <= 0;
    end else if (ov && out_ready) begin
      n_out <= n_out + 1;
      if (ol) n_last <= n_last + 1;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_row(input acc_t a0, input acc_t a1);
    for (int i = 0; i < SIZE; i++) data_in[i] = a0;
    data_in[1] = a1;
  endtask
  task automatic load_cfg(input acc_t m, input logic signed [5:0] s, input q8_t z, input q8_t lo, input q8_t hi);
    mult = m;
    shift = s;
    zp = z;
    amin = lo;
    amax = hi;
    cfg_load = 1;
    tick;
    cfg_load = 0;
  endtask
  task automatic do_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
  endtask
  task automatic run_row(input string tag, input acc_t a0, input acc_t a1, input logic [7:0] e0, input logic [7:0] e1);
    set_row(a0, a1);
    calc_done = 1;
    tick;
    calc_done = 0;
    chk({tag, "_n1"}, ov, 0);
    tick;
    chk({tag, "_n2"}, ov, 0);
    tick;
    chk({tag, "_valid"}, ov, 1);
    chk({tag, "_lane0"}, od[7:0], e0);
    chk({tag, "_lane1"}, od[15:8], e1);
    tick;
  endtask
  initial begin
    set_row(0, 0);
    tick;
    tick;
    chk("rst_valid", ov, 0);
    chk("rst_last", ol, 0);
    chk("rst_data", od, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rowerr", rerr, 0);
    chk("rst_idle", idle, 1);
    rst = 0;
    load_cfg(32'sh40000000, 6'sd0, 8'sd0, 8'sh80, 8'sh7F);
    run_row("basic", 100, -100, 8'h32, 8'hCE);
    load_cfg(32'sh40000000, 6'sh3F, 8'sh80, 8'sh80, 8'sh7F);
    run_row("rshift", 5, -5, 8'h82, 8'h80);
    load_cfg(32'sh7FFFFFFF, 6'sd0, 8'sd10, -8'sd100, 8'sh7F);
    run_row("clamp", 1000, -1000, 8'h7F, 8'h9C);
    load_cfg(32'sh40000000, 6'sd2, 8'sd0, 8'sh80, 8'sh7F);
    run_row("lshift", 3, 32'sh40000001, 8'h06, 8'h02);
    load_cfg(32'sh80000000, 6'sd0, 8'sd0, 8'sh80, 8'sh7F);
    run_row("sat", 32'sh80000000, 1, 8'h7F, 8'hFF);
    do_reset;
    load_cfg(32'sh40000000, 6'sd0, 8'sd0, 8'sh80, 8'sh7F);
    out_ready = 0;
    for (int k = 0; k < SIZE; k++) begin
      set_row(2 * k + 2, 100);
      calc_done = 1;
      tick;
    end
    calc_done = 0;
    mult = 0;
    cfg_load = 1;
    tick;
    cfg_load = 0;
    tick;
    tick;
    tick;
    chk("stall_valid", ov, 1);
    chk("stall_data", od[7:0], 1);
    chk("stall_last", ol, 0);
    chk("ovf_depth16", ovf, 0);
    chk("ovf_depth4", ovf4, 1);
    tile_over = 1;
    tick;
    tile_over = 0;
    chk("stall_hold", od[7:0], 1);
    chk("rowerr_full_tile", rerr, 0);
    out_ready = 1;
    for (int k = 0; k < SIZE; k++) begin
      chk("drain_valid", ov, 1);
      chk("drain_data", od[7:0], k + 1);
      chk("drain_last", ol, k == SIZE - 1);
      tick;
    end
    chk("drain_end", ov, 0);
    chk("ovf_sticky", ovf4, 1);
    do_reset;
    load_cfg(32'sh40000000, 6'sd0, 8'sd0, 8'sh80, 8'sh7F);
    for (int k = 0; k < SIZE - 1; k++) begin
      set_row(2 * k + 2, 100);
      calc_done = 1;
      tick;
    end
    calc_done = 0;
    tile_over = 1;
    tick;
    tile_over = 0;
    chk("rowerr_short", rerr, 1);
    chk("rowerr_short4", rerr4, 1);
    repeat (5) tick;
    chk("short_idle", idle, 1);
    do_reset;
    load_cfg(32'sh40000000, 6'sd0, 8'sd0, 8'sh80, 8'sh7F);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      set_row(2 * k + 2, 100);
      calc_done = 1;
      tick;
    end
    calc_done = 0;
    rst = 1;
    tick;
    chk("midrst_valid", ov, 0);
    chk("midrst_idle", idle, 1);
    rst = 0;
    load_cfg(32'sh40000000, 6'sd0, 8'sd0, 8'sh80, 8'sh7F);
    out_ready = 1;
    for (int k = 0; k < SIZE; k++) begin
      set_row(2 * k + 2, 100);
      calc_done = 1;
      tick;
    end
    calc_done = 0;
    tile_over = 1;
    tick;
    tile_over = 0;
    repeat (6) tick;
    chk("clean_rows", n_out, SIZE);
    chk("clean_last", n_last, 1);
    chk("clean_rowerr", rerr, 0);
    chk("clean_idle", idle, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/requant_drain.md
Name: requant_drain

Overview:
- Sits directly downstream of the systolic accumulator array and consumes its row stream: one row of SIZE int32 partial sums per cycle while calc_done_i is high, SIZE rows per tile.
- Buffers rows in an internal FIFO, because the upstream array has no backpressure.
- Requantizes each lane to int8 using TFLM per-tensor semantics: optional bias add, doubling-high multiply, rounding shift, output zero point, activation clamp.
- Emits packed int8 rows over a valid/ready interface to the output buffer writer.

Parameters:
- SIZE, 16, lanes per row and rows per tile.
- DATA_WIDTH, 32, accumulator lane width; must be 32.
- FIFO_DEPTH, 16, row FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- data_in  in  DATA_WIDTH x [0:SIZE-1]  signed accumulator row.
- calc_done_i  in  1  data_in valid this cycle.
- tile_calc_over_i  in  1  one-cycle pulse after the last row of a tile.
- cfg_load_i  in  1  capture quant config; honoured only when idle.
- quant_mult_i  in  32  signed Q31 multiplier.
- quant_shift_i  in  6  signed shift: >0 left shift before the multiply, <0 rounding right shift after it; range -31..+7.
- out_zp_i  in  8  signed output zero point.
- act_min_i / act_max_i  in  8 each  signed clamp bounds.
- bias_i  in  32 x [0:SIZE-1]  signed per-lane bias (present only with the optional feature).
- out_data  out  SIZE*8  lane i at bits [8i+7:8i].
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream ready.
- out_last  out  1  high with the last row of a tile.
- idle_o  out  1  FIFO and pipeline empty.
- ovf_o  out  1  sticky: a row arrived while the FIFO was full.
- row_err_o  out  1  sticky: tile_calc_over_i arrived with write row count != SIZE.

Behaviour:
- Reset values: out_valid=0, out_last=0, out_data=0, ovf_o=0, row_err_o=0, idle_o=1. The FIFO and pipeline are flushed, both row counters are 0, and config registers go to mult=0, shift=0, zp=0, min=-128, max=127.
- Reset mid-operation drops all in-flight rows with no output. It takes priority over every other input in the same cycle.
- Write side:
  - calc_done_i=1 with FIFO not full: push the row and increment wr_row_cnt.
  - calc_done_i=1 with FIFO full: drop the row and set ovf_o. wr_row_cnt still increments.
  - tile_calc_over_i: set row_err_o if wr_row_cnt != SIZE, then clear wr_row_cnt. If it coincides with a push, the push is counted first.
- Pipeline: FIFO -> S1 (shift-left + multiply) -> S2 (round, zero point, clamp; S2 is the output register).
  - One global enable: adv = !out_valid || out_ready. All stages move together when adv=1.
  - The FIFO pops when adv=1 and it is non-empty.
  - Push and pop in the same cycle are legal even when the FIFO is full (no overflow in that case).
- Latency: with an empty pipeline and out_ready=1, a row sampled with calc_done_i in cycle N gives out_valid=1 in cycle N+3.
- Throughput: 1 row per cycle while out_ready=1.
- Handshake: out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Per-lane arithmetic (all signed):
  - a = acc (+ bias, 32-bit wrap).
  - If shift>0: a = a << shift, 32-bit wrap.
  - p = a * mult (64-bit).
  - Saturation case: a = mult = -2^31 gives h = 2^31-1.
  - Otherwise nudge = (p >= 0) ? 2^30 : 1-2^30, and h = trunc_toward_zero((p + nudge) / 2^31).
  - If shift<0, with s = -shift: mask = 2^s - 1, rem = h & mask, thr = (mask >> 1) + (h < 0). r = (h >>> s) + (rem > thr).
  - Otherwise r = h.
  - o = clamp(r + zp, max(act_min, -128), min(act_max, 127)).
- Tile framing: rd_row_cnt counts rows leaving S2 on the handshake. out_last=1 when rd_row_cnt == SIZE-1. The counter wraps to 0 after the last row.
- Config:
  - cfg_load_i with idle_o=1 captures all config inputs at the clock edge.
  - cfg_load_i while busy is ignored.
  - Config must not change mid-tile.

Optional Feature:
- Macro: REQUANT_DRAIN_BIAS_EN.
- Defined: bias_i exists and is registered on cfg_load_i; the per-lane bias is added before the shift.
- Undefined: the bias_i port is absent and a = acc. Stage count and latency are unchanged.

Decomposition:
- Package requant_pkg holds:
  - acc_t (int32), q8_t (int8), quant_cfg_t (mult, shift, zp, act_min, act_max);
  - constants Q31_NUDGE_POS and Q31_NUDGE_NEG;
  - function srdhm() (saturating rounding doubling high multiply) and function rdpot() (rounding divide by power of two).
- One sub-module, requant_lane: the per-lane S1/S2 datapath with its enable. It is instantiated SIZE times by generate.
- The FIFO is inline: a register array plus read/write pointers with an extra wrap bit.

Test Plan:
- acc=100, mult=0x40000000, shift=0, zp=0, min/max=-128/127 -> lane out 50; out_valid exactly 3 cycles after calc_done_i.
- acc=5, mult=0x40000000, shift=-1, zp=-128 -> h=3, r=2, out -126.
- acc=1000, mult=0x7FFFFFFF, zp=10, act_max=127 -> 127 (clamp); acc=-1000 with act_min=-100 -> -100.
- 16 rows with calc_done_i held high, out_ready=0 for 20 cycles, FIFO_DEPTH=16 -> ovf_o stays 0; all 16 rows emerge in order; out_last only on row 16; out_data stable during the stall.
- FIFO_DEPTH=4, out_ready=0, 16 rows -> ovf_o=1 sticky; tile of 15 rows then tile_calc_over_i -> row_err_o=1.
- rst asserted mid-tile with 3 rows buffered -> next cycle out_valid=0, idle_o=1; a following clean tile produces exactly 16 rows.
